// File: rtl/uart_cmd_master_pkg.sv
// Shared opcodes, command/state encodings and the frame builder
// for the UART command master.
package uart_cmd_master_pkg;

    localparam logic [7:0] OPC_REG_WR    = 8'hAA;
    localparam logic [7:0] OPC_REG_RD    = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPER  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOPER = 8'hDD;

    typedef enum logic [1:0] {
        OP_REG_WR    = 2'd0,
        OP_REG_RD    = 2'd1,
        OP_ALU_OPER  = 2'd2,
        OP_ALU_NOPER = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0][7:0] bytes;
        logic [1:0]      last;
        logic [1:0]      rsp_len;
    } frame_t;

    // bytes[0] is always the opcode; unused tail bytes are zero
    function automatic frame_t build_frame(
        input cmd_op_e    op,
        input logic [3:0] addr,
        input logic [7:0] wdata,
        input logic [7:0] op_a,
        input logic [7:0] op_b,
        input logic [3:0] fun
    );
        frame_t f;
        f = '0;
        unique case (op)
            OP_REG_WR: begin
                f.bytes   = {8'h00, wdata, {4'h0, addr}, OPC_REG_WR};
                f.last    = 2'd2;
                f.rsp_len = 2'd0;
            end
            OP_REG_RD: begin
                f.bytes   = {16'h0000, {4'h0, addr}, OPC_REG_RD};
                f.last    = 2'd1;
                f.rsp_len = 2'd1;
            end
            OP_ALU_OPER: begin
                f.bytes   = {{4'h0, fun}, op_b, op_a, OPC_ALU_OPER};
                f.last    = 2'd3;
                f.rsp_len = 2'd2;
            end
            OP_ALU_NOPER: begin
                f.bytes   = {16'h0000, {4'h0, fun}, OPC_ALU_NOPER};
                f.last    = 2'd1;
                f.rsp_len = 2'd2;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/uart_cmd_master_rsp_timer.sv
// Response inactivity timer: counts idle cycles while enabled and
// flags expiry on the last permitted cycle.
module rsp_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_master.sv
// Sends register/ALU command frames to a UART byte transmitter and
// collects the byte response, with an inactivity abort.
module uart_cmd_master
    import uart_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_op_a,
    input  logic [7:0]  cmd_op_b,
    input  logic [3:0]  cmd_fun,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    state_e     state;
    frame_t     cur;
    frame_t     nxt;
    logic [1:0] byte_idx;
    logic [1:0] rx_cnt;
    logic [7:0] rx_lo;
    logic       tmr_en;
    logic       tmr_clear;
    logic       tmr_expire;

    always_comb begin
        nxt = build_frame(cmd_op_e'(cmd_op), cmd_addr, cmd_wdata,
                          cmd_op_a, cmd_op_b, cmd_fun);
    end

    // counter is held at zero outside WAIT_RSP, so entry starts it clean
    assign tmr_en    = (state == ST_WAIT_RSP);
    assign tmr_clear = !tmr_en || rx_valid;

    rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk   (CLK),
        .rst_n (RST),
        .clear (tmr_clear),
        .enable(tmr_en),
        .expire(tmr_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            cur         <= '0;
            byte_idx    <= '0;
            rx_cnt      <= '0;
            rx_lo       <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur       <= nxt;
                        byte_idx  <= '0;
                        tx_data   <= nxt.bytes[0];
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == cur.last) begin
                            tx_valid <= 1'b0;
                            rx_cnt   <= '0;
                            if (cur.rsp_len == 2'd0) begin
                                rsp_data  <= '0;
                                rsp_valid <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_WAIT_RSP;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= cur.bytes[byte_idx + 2'd1];
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    // a byte on the expiry cycle wins over the abort
                    if (rx_valid) begin
                        if (rx_cnt + 2'd1 == cur.rsp_len) begin
                            rsp_data  <= (cur.rsp_len == 2'd1)
                                       ? {8'h00, rx_data}
                                       : {rx_data, rx_lo};
                            rsp_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rx_lo  <= rx_data;
                            rx_cnt <= rx_cnt + 2'd1;
                        end
                    end else if (tmr_expire) begin
                        rsp_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Randomized bench for uart_cmd_master with a frame/response model
// and a per-cycle output checker.
module tb_uart_cmd_master;

    localparam int T = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [7:0]  cmd_op_a = '0;
    logic [7:0]  cmd_op_b = '0;
    logic [3:0]  cmd_fun = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    uart_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_op_a   (cmd_op_a),
        .cmd_op_b   (cmd_op_b),
        .cmd_fun    (cmd_fun),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [15:0] exp_rsp_data = '0;
    logic [15:0] exp_rsp_next = '0;
    bit          pend_rsp = 0;
    bit          pend_to = 0;
    bit          got_rsp = 0;
    bit          got_to = 0;
    bit          model_idle = 1;
    bit          prev_hold = 0;
    logic [7:0]  prev_data = '0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", nm);
    endtask

    function automatic void push_frame(input logic [1:0] op,
        input logic [3:0] addr, input logic [7:0] wd,
        input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        case (op)
            2'd0: begin
                exp_tx.push_back(8'hAA);
                exp_tx.push_back({4'h0, addr});
                exp_tx.push_back(wd);
            end
            2'd1: begin
                exp_tx.push_back(8'hBB);
                exp_tx.push_back({4'h0, addr});
            end
            2'd2: begin
                exp_tx.push_back(8'hCC);
                exp_tx.push_back(a);
                exp_tx.push_back(b);
                exp_tx.push_back({4'h0, fun});
            end
            default: begin
                exp_tx.push_back(8'hDD);
                exp_tx.push_back({4'h0, fun});
            end
        endcase
    endfunction

    function automatic int rsp_count(input logic [1:0] op);
        return (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
    endfunction

    always @(negedge CLK) begin
        cyc++;
        chk("tx_valid", tx_valid, exp_tx.size() != 0);
        if (prev_hold && RST) chk("tx_hold", tx_data, prev_data);
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() > 0) chk("tx_data", tx_data, exp_tx.pop_front());
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        prev_hold = RST && tx_valid && !tx_ready;
        prev_data = tx_data;
        if (rsp_valid) begin
            if (!pend_rsp) fail("rsp_valid_unexpected");
            else begin
                exp_rsp_data = exp_rsp_next;
                pend_rsp = 0;
                got_rsp = 1;
            end
        end
        if (rsp_timeout) begin
            if (!pend_to) fail("rsp_timeout_unexpected");
            else begin
                pend_to = 0;
                got_to = 1;
                model_idle = 1;
            end
        end
        chk("rsp_data", rsp_data, exp_rsp_data);
        chk("cmd_ready", cmd_ready, model_idle);
        chk("busy", busy, !model_idle);
        if (rsp_valid) model_idle = 1;
    end

    task automatic do_reset();
        RST = 1'b0;
        exp_tx.delete();
        model_idle = 1;
        exp_rsp_data = '0;
        pend_rsp = 0;
        pend_to = 0;
        rx_valid = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pulses", {rsp_valid, rsp_timeout}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    // mode: 0 normal, 1 no response (timeout), 2 rx on expiry cycle,
    // 3 reset after the second frame byte
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr,
        input logic [7:0] wd, input logic [7:0] a, input logic [7:0] b,
        input logic [3:0] fun, input int txm, input int gap,
        input int mode, input logic [7:0] r0, input logic [7:0] r1);
        int n;
        int k;
        int g;
        int cnt;
        bit tog;
        logic [31:0] r;
        logic [7:0] rb[2];
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_wdata = wd;
        cmd_op_a = a;
        cmd_op_b = b;
        cmd_fun = fun;
        n = 0;
        while (!cmd_ready) begin
            @(negedge CLK);
            n++;
            if (n > 60) begin
                fail("accept_wait");
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        #1;
        r = $urandom;
        cmd_valid = 1'b0;
        cmd_op = r[1:0];
        cmd_addr = r[7:4];
        cmd_wdata = r[15:8];
        cmd_op_a = r[23:16];
        cmd_op_b = r[31:24];
        cmd_fun = r[11:8];
        model_idle = 0;
        got_rsp = 0;
        got_to = 0;
        push_frame(op, addr, wd, a, b, fun);
        n = 0;
        tog = 1;
        while (exp_tx.size() > 0) begin
            if (mode == 3 && exp_tx.size() == 2) begin
                do_reset();
                return;
            end
            r = $urandom;
            tx_ready = (txm == 0) ? 1'b1 : (txm == 1) ? tog : r[0];
            tog = !tog;
            rx_valid = (r[3:2] == 2'b00);
            rx_data = r[15:8];
            @(posedge CLK);
            #1;
            n++;
            if (n > 200) begin
                fail("send_stall");
                return;
            end
        end
        rx_valid = 1'b0;
        cnt = rsp_count(op);
        rb[0] = r0;
        rb[1] = r1;
        if (cnt > 0 && mode == 1) begin
            pend_to = 1;
            k = 0;
            while (!got_to && k < 3 * T) begin
                @(negedge CLK);
                #1;
                k++;
            end
            chk("timeout_cycles", k, T + 1);
            chk("ready_after_timeout", cmd_ready, 1);
            return;
        end
        exp_rsp_next = (cnt == 0) ? 16'h0000
                     : (cnt == 1) ? {8'h00, r0} : {r1, r0};
        pend_rsp = 1;
        for (int i = 0; i < cnt; i++) begin
            if (mode == 2 && i == 0) g = T - 1;
            else if (gap >= 0) g = gap;
            else g = $urandom_range(0, T - 1);
            repeat (g) begin
                @(posedge CLK);
                #1;
            end
            rx_valid = 1'b1;
            rx_data = rb[i];
            @(posedge CLK);
            #1;
            rx_valid = 1'b0;
        end
        k = 0;
        while (!got_rsp && k < 10) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("rsp_latency", k, 1);
    endtask

    task automatic check_log(input string nm, input logic [31:0] e,
                             input int n);
        logic [31:0] v;
        chk({nm, "_len"}, tx_log.size(), n);
        for (int i = 0; i < n; i++) begin
            v = e >> (8 * (n - 1 - i));
            if (i < tx_log.size()) chk(nm, tx_log[i], v[7:0]);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] s;
        int md;
        int mode;
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        repeat (3) @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        tx_log.delete();
        tx_cyc.delete();
        run_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, -1, 0,
                8'h00, 8'h00);
        check_log("reg_wr_bytes", 32'h00AA053C, 3);
        if (tx_cyc.size() == 3) chk("reg_wr_gapless", tx_cyc[2] - tx_cyc[0], 2);
        chk("reg_wr_rsp", rsp_data, 16'h0000);

        tx_log.delete();
        run_cmd(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 10, 0,
                8'h47, 8'h00);
        check_log("reg_rd_bytes", 32'h0000BB02, 2);
        chk("reg_rd_rsp", rsp_data, 16'h0047);

        tx_log.delete();
        run_cmd(2'd2, 4'd0, 8'h00, 8'h12, 8'h34, 4'h1, 1, -1, 0,
                8'h46, 8'h00);
        check_log("alu_bytes", 32'hCC123401, 4);
        chk("alu_rsp", rsp_data, 16'h0046);

        run_cmd(2'd2, 4'd0, 8'h00, 8'h9A, 8'hBC, 4'h7, 2, -1, 3,
                8'h00, 8'h00);
        run_cmd(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'h0, 2, -1, 0,
                8'hE1, 8'h00);
        chk("post_reset_rsp", rsp_data, 16'h00E1);

        run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h5, 2, -1, 1,
                8'h00, 8'h00);
        chk("timeout_keeps_rsp", rsp_data, 16'h00E1);
        run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'hA, 2, -1, 2,
                8'h5A, 8'hC3);
        chk("expiry_rx_rsp", rsp_data, 16'hC35A);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            s = $urandom;
            md = $urandom_range(0, 5);
            mode = (md == 0) ? 1 : (md == 1) ? 2 : 0;
            run_cmd(r[1:0], r[7:4], r[15:8], r[23:16], r[31:24],
                    s[3:0], 2, -1, mode, s[15:8], s[23:16]);
        end

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
